// File: rtl/syn_fifo_param.sv
// Parametrised single-clock FIFO with threshold flags, occupancy count, flush and error pulses.
// Define SYN_FIFO_FWFT_EN for first-word-fall-through reads; otherwise rd_data is registered on pop.
module syn_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    wr_en,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    rd_en,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    fifo_full,
  output logic                    fifo_empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  data_cnt,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;
  localparam ptr_t ONE  = ptr_t'(1);
  localparam ptr_t AF_L = ptr_t'(AF_LEVEL);
  localparam ptr_t AE_L = ptr_t'(AE_LEVEL);

  logic [DATA_W-1:0] mem_q [DEPTH];
  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  ptr_t cnt_q, cnt_d;
  logic full_q, empty_q, af_q, ae_q, ovf_q, udf_q;
  logic full_d, empty_d;
  logic rd_accept, wr_accept;

  // A full FIFO may still take a write when the same edge pops the head.
  assign rd_accept = rd_en && !empty_q;
  assign wr_accept = wr_en && (!full_q || rd_accept);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr_accept) wr_ptr_d = wr_ptr_q + ONE;
      if (rd_accept) rd_ptr_d = rd_ptr_q + ONE;
      case ({wr_accept, rd_accept})
        2'b10:   cnt_d = cnt_q + ONE;
        2'b01:   cnt_d = cnt_q - ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  assign full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  assign empty_d = (wr_ptr_d == rd_ptr_d);

  // Storage is never reset or cleared; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (!flush && wr_accept) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= (cnt_d >= AF_L);
      ae_q     <= (cnt_d <= AE_L);
      ovf_q    <= !flush && wr_en && !wr_accept;
      udf_q    <= !flush && rd_en && !rd_accept;
    end
  end

`ifdef SYN_FIFO_FWFT_EN
  // Head word is exposed directly; driven to zero while nothing valid is held.
  assign rd_data = empty_q ? '0 : mem_q[rd_ptr_q[AW-1:0]];
`else
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (!flush && rd_accept) begin
      rd_data_q <= mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  assign rd_data = rd_data_q;
`endif

  assign fifo_full    = full_q;
  assign fifo_empty   = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign data_cnt     = cnt_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule
